// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode encoding and latency helpers.
// Used by the decoder, the MDU and the issue controller.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic {
        BSY_IDLE = 1'b0,
        BSY_BUSY = 1'b1
    } busy_state_e;

    // Encodings above MTLO are reserved and behave as no-op.
    function automatic logic [3:0] op_eff(input logic [3:0] op);
        return (op > MDU_MTLO) ? MDU_NONE : op;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    function automatic int op_lat(
        input logic [3:0] op,
        input int         mul_lat,
        input int         div_lat
    );
        int lat;
        lat = 0;
        unique case (1'b1)
            (op == MDU_MULT) || (op == MDU_MULTU): lat = mul_lat;
            (op == MDU_DIV)  || (op == MDU_DIVU):  lat = div_lat;
            default:                              lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Decode/E-stage bundle between the pipeline and the MDU issue controller.
// master = pipeline side, slave = issue controller.
interface mdu_issue_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             d_valid;
    logic [3:0]       d_mdu_op;
    logic [31:0]      d_rs;
    logic [31:0]      d_rt;
    logic             ext_stall;
    logic             req;
    logic [3:0]       e_mdu_op;
    logic [31:0]      e_a;
    logic [31:0]      e_b;
    logic             e_start;
    logic             e_req;
    logic             stall_d;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    modport master (
        output d_valid, d_mdu_op, d_rs, d_rt, ext_stall, req,
        input  e_mdu_op, e_a, e_b, e_start, e_req, stall_d, busy, cnt
    );

    modport slave (
        input  d_valid, d_mdu_op, d_rs, d_rt, ext_stall, req,
        output e_mdu_op, e_a, e_b, e_start, e_req, stall_d, busy, cnt
    );
endinterface

// File: rtl/mdu_busy_fsm.sv
// Busy-window tracker for the MDU: IDLE/BUSY with a countdown
// loaded from the started op's latency.
module mdu_busy_fsm
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [3:0]       op,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if ((MUL_LAT > CNT_MAX) || (DIV_LAT > CNT_MAX)) begin : g_lat_chk
        $error("mdu_busy_fsm: latency does not fit in CNT_W");
    end

    busy_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BSY_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while BUSY is dropped; the running count wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BSY_IDLE: begin
                if (md_start) begin
                    state_d = BSY_BUSY;
                    cnt_d   = CNT_W'(op_lat(op, MUL_LAT, DIV_LAT));
                end
            end
            BSY_BUSY: begin
                if (cnt_q != '0) cnt_d = cnt_q - ONE;
                if (cnt_q <= ONE) state_d = BSY_IDLE;
            end
            default: begin
                state_d = BSY_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BSY_BUSY) || md_start;
    assign cnt  = cnt_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// D/E issue controller for the MDU: E-stage op/operand register,
// start strobe and decode stall against the MDU busy window.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset,
    mdu_issue_ctrl_if.slave  bus
);

    logic [3:0]       d_op;
    logic [3:0]       e_op_q;
    logic [31:0]      e_a_q;
    logic [31:0]      e_b_q;
    logic             e_start;
    logic             md_start;
    logic             busy;
    logic             stall_d;
    logic             flush;
    logic [CNT_W-1:0] cnt;

    assign d_op     = op_eff(bus.d_mdu_op);
    assign e_start  = (e_op_q != MDU_NONE) && !bus.req;
    assign md_start = e_start && is_muldiv(e_op_q);

    mdu_busy_fsm #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_busy (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .op       (e_op_q),
        .busy     (busy),
        .cnt      (cnt)
    );

    // Any MDU op waits out the window, including HI/LO moves.
    assign stall_d = bus.d_valid && (d_op != MDU_NONE) && busy;
    assign flush   = bus.req || stall_d || bus.ext_stall;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            e_op_q <= MDU_NONE;
            e_a_q  <= '0;
            e_b_q  <= '0;
        end else begin
            e_op_q <= bus.d_valid ? d_op : MDU_NONE;
            e_a_q  <= bus.d_rs;
            e_b_q  <= bus.d_rt;
        end
    end

    assign bus.e_mdu_op = e_op_q;
    assign bus.e_a      = e_a_q;
    assign bus.e_b      = e_b_q;
    assign bus.e_start  = e_start;
    assign bus.e_req    = bus.req;
    assign bus.stall_d  = stall_d;
    assign bus.busy     = busy;
    assign bus.cnt      = cnt;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios then random traffic,
// checked against a cycle-timestamp reference model.
module tb_mdu_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mdu_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: E register contents plus the absolute cycle span of the
    // last accepted mul/div (busy from bstart through bend).
    int          cyc    = 0;
    int          bstart = -100;
    int          bend   = -100;
    logic [3:0]  m_op   = 4'd0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endfunction

    task automatic set_d(input logic v, input logic [3:0] op,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.d_valid  = v;
        bus.d_mdu_op = op;
        bus.d_rs     = rs;
        bus.d_rt     = rt;
    endtask

    task automatic step();
        logic [3:0] oe;
        logic       es, md, infl, bz, st;
        int         c;
        @(negedge clk);
        oe   = (bus.d_mdu_op <= 4'd8) ? bus.d_mdu_op : 4'd0;
        infl = (cyc > bstart) && (cyc <= bend);
        es   = (m_op != 4'd0) && !bus.req;
        md   = es && (m_op >= 4'd1) && (m_op <= 4'd4);
        bz   = infl || md;
        c    = infl ? (bend - cyc + 1) : 0;
        st   = bus.d_valid && (oe != 4'd0) && bz;
        chk("e_mdu_op", 32'(bus.e_mdu_op), 32'(m_op));
        chk("e_a",      bus.e_a,           m_a);
        chk("e_b",      bus.e_b,           m_b);
        chk("e_start",  32'(bus.e_start),  32'(es));
        chk("e_req",    32'(bus.e_req),    32'(bus.req));
        chk("stall_d",  32'(bus.stall_d),  32'(st));
        chk("busy",     32'(bus.busy),     32'(bz));
        chk("cnt",      32'(bus.cnt),      c);
        @(posedge clk);
        if (reset) begin
            m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
            bstart = -100; bend = -100;
        end else begin
            if (md && !infl) begin
                bstart = cyc;
                bend   = cyc + ((m_op <= 4'd2) ? MUL_LAT : DIV_LAT);
            end
            if (bus.req || st || bus.ext_stall) begin
                m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
            end else begin
                m_op = bus.d_valid ? oe : 4'd0;
                m_a  = bus.d_rs;
                m_b  = bus.d_rt;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 1'b0;
        bus.ext_stall = 1'b0;
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        steps(2);
        reset = 1'b0;
        steps(1);

        // MULT 3*5 followed by a waiting MFLO
        set_d(1'b1, 4'd1, 32'd3, 32'd5);
        step();
        set_d(1'b1, 4'd6, 32'd0, 32'd0);
        steps(8);
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(2);

        // DIVU, ADD (non-MDU), then MFHI
        set_d(1'b1, 4'd4, 32'd100, 32'd7);
        step();
        set_d(1'b1, 4'd0, 32'h11, 32'h22);
        step();
        set_d(1'b1, 4'd5, 32'd0, 32'd0);
        steps(12);
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(2);

        // DIV reaching E together with req
        set_d(1'b1, 4'd3, 32'd9, 32'd2);
        step();
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        steps(2);

        // req while a MULT is counting
        set_d(1'b1, 4'd2, 32'd7, 32'd8);
        step();
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(2);
        set_d(1'b1, 4'd8, 32'd1, 32'd1);
        bus.req = 1'b1;
        steps(2);
        bus.req = 1'b0;
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(5);

        // MTHI held by ext_stall, then issues
        set_d(1'b1, 4'd7, 32'hDEADBEEF, 32'd1);
        bus.ext_stall = 1'b1;
        steps(2);
        bus.ext_stall = 1'b0;
        step();
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(2);

        // reset in the middle of a DIV count
        set_d(1'b1, 4'd3, 32'd50, 32'd5);
        step();
        set_d(1'b0, 4'd0, 32'd0, 32'd0);
        steps(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(3);

        // reserved opcodes behave as none
        set_d(1'b1, 4'd12, 32'd1, 32'd2);
        steps(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            set_d(1'($urandom % 2), 4'($urandom_range(0, 15)),
                  $urandom, $urandom);
            bus.req       = ($urandom % 10) == 0;
            bus.ext_stall = ($urandom % 6) == 0;
            reset         = ($urandom % 200) == 0;
            step();
        end
        reset = 1'b0;
        bus.req = 1'b0;
        bus.ext_stall = 1'b0;
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- D/E-stage issue controller for the multiply/divide unit.
- Latches the MDU opcode and operands from decode into an E-stage register and drives the MDU start strobe.
- Tracks the multi-cycle busy window with a countdown FSM and raises the decode-stage stall for any MDU instruction that would collide.
- Sits directly upstream of the MDU and feeds its op/A/B/start/req inputs; consumed by the pipeline hazard unit.

Parameters:
- MUL_LAT, 5, busy cycles after a MULT/MULTU start.
- DIV_LAT, 10, busy cycles after a DIV/DIVU start.
- CNT_W, 4, countdown width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  decode-stage instruction valid
- d_mdu_op  in  4  decode MDU opcode: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as 0
- d_rs  in  32  forwarded rs value (becomes A)
- d_rt  in  32  forwarded rt value (becomes B)
- ext_stall  in  1  stall of decode from other hazards
- req  in  1  exception/interrupt request; flushes E this cycle
- e_mdu_op  out  4  E-stage opcode to MDU
- e_a  out  32  E-stage operand A
- e_b  out  32  E-stage operand B
- e_start  out  1  MDU start strobe
- e_req  out  1  registered-through copy of req (combinational passthrough)
- stall_d  out  1  MDU-caused decode stall
- busy  out  1  MDU busy (FSM not IDLE, or a mul/div starting this cycle)
- cnt  out  CNT_W  remaining busy cycles (debug/verification)

Behaviour:
- Reset (synchronous): E register becomes a bubble (e_mdu_op=0, e_a=0, e_b=0); FSM goes to IDLE; cnt=0. Resulting outputs: e_start=0, stall_d=0, busy=0. Reset mid-operation abandons the count immediately.
- e_start = (e_mdu_op != 0) && !req. A MDU start is never issued in a req cycle.
- e_req = req (combinational).
- md_start = e_start && e_mdu_op in 1..4.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on md_start. cnt loads MUL_LAT for ops 1/2 and DIV_LAT for ops 3/4.
  - BUSY: cnt decrements by 1 each cycle. The edge that takes cnt from 1 to 0 returns the FSM to IDLE.
  - md_start while BUSY cannot occur (guaranteed by stall). If it does, it is ignored and the count continues.
- busy = (state==BUSY) || md_start.
- Busy window: a mul started in cycle t keeps busy=1 for cycles t..t+MUL_LAT; a div, for cycles t..t+DIV_LAT.
- stall_d = d_valid && d_op_eff != 0 && busy.
  - Every MDU op is stalled while busy, including MFHI/MFLO/MTHI/MTLO.
  - Non-MDU instructions are never stalled by this block.
- E-register update each edge, in priority order:
  1. reset -> bubble.
  2. req -> bubble.
  3. stall_d || ext_stall -> bubble.
  4. Otherwise load {d_valid ? d_op_eff : 0, d_rs, d_rt}.
- req semantics:
  - An in-flight mul/div (FSM BUSY) is not cancelled by req; it completes its count.
  - req only kills the E-stage instruction and suppresses its start.
- Simultaneous events:
  - md_start in the same cycle as req: no start; the FSM stays IDLE.
  - stall_d and ext_stall together: bubble, single stall.
  - Countdown reaching 0 in the same cycle a D-stage MDU op waits: stall_d=0 that cycle only if the FSM is already IDLE. The D op issues on the next edge after busy falls.
- Widths:
  - cnt saturates at 0 and never wraps.
  - MUL_LAT/DIV_LAT > 2^CNT_W-1 is illegal; the implementation asserts on it in simulation.

Decomposition:
- Shared package (mdu_pkg), shared with the MDU and decoder:
  - opcode constants MDU_NONE..MDU_MTLO (4-bit).
  - helper function is_muldiv(op).
  - helper function op_lat(op).
- Natural sub-module: mdu_busy_fsm (IDLE/BUSY state, cnt load/decrement, busy output).
- The top holds the E register and stall logic.

Test Plan:
- MULT in D, A=3, B=5, no hazards -> E captures op=1, e_start=1 in the next cycle; busy=1 for 6 cycles; cnt 5,4,3,2,1,0; back-to-back MFLO stalled exactly 6 cycles then issues with e_mdu_op=6.
- DIVU A=100, B=7, followed by an ADD then MFHI -> ADD never stalled; MFHI stall_d=1 until busy=0 (11 cycles from start); E gets bubbles meanwhile.
- DIV reaches E in a cycle with req=1 -> e_start=0, FSM stays IDLE, E bubble next cycle, busy=0.
- req asserted during cnt=4 of a MULT -> count continues 3,2,1,0; no start strobes; E flushed.
- ext_stall=1 with MTHI in D, FSM IDLE -> stall_d=0; E loads a bubble; MTHI issues on the first cycle ext_stall=0 (e_a = d_rs = 0xDEADBEEF).
- reset asserted at cnt=7 of a DIV -> next cycle state IDLE, cnt=0, busy=0, stall_d=0, e_mdu_op=0.
